i2c_apb_regs: RTL and testbench

- APB3 slave register bank sitting directly upstream of the I2C core.
- Drives the core's control register, slave address, TX FIFO write port, RX FIFO read strobe, RX programmable-full threshold, debounce count and the eight bus-timing values.
- Captures the core's status, FIFO occupancy, RX data and raw interrupt requests, and produces one level interrupt to the CPU.

---
 rtl/i2c_apb_regs.sv | 190 +++++++++++++++++++
 tb/tb_i2c_apb_regs.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_apb_regs.sv
// APB3 register bank in front of the I2C core: control/timing registers, FIFO ports, interrupt capture.
// Define I2C_APB_RDWAIT_EN to give every read one wait state with a registered read sample.
module i2c_apb_regs #(
  parameter int          AW     = 8,
  parameter logic [31:0] T_RST  = 32'd100,
  parameter logic [13:0] DB_RST = 14'd10
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [AW-1:0] paddr,
  input  logic [31:0]   pwdata,
  output logic [31:0]   prdata,
  output logic          pready,
  output logic          pslverr,
  output logic          irq,
  output logic [7:0]    cr,
  output logic          cr_msms,
  output logic [9:0]    slv_adr,
  output logic          tx_fifo_wr,
  output logic [9:0]    tx_fifo_din,
  output logic          rx_fifo_rd,
  output logic [4:0]    rx_fifo_pirq,
  output logic [13:0]   debounce_cnt,
  output logic [31:0]   tsusta,
  output logic [31:0]   thdsta,
  output logic [31:0]   tsusto,
  output logic [31:0]   tsudat,
  output logic [31:0]   thddat,
  output logic [31:0]   tlow,
  output logic [31:0]   thigh,
  output logic [31:0]   tbuf,
  input  logic [7:0]    sr,
  input  logic [7:0]    irq_req,
  input  logic [4:0]    tx_fifo_ocy,
  input  logic [4:0]    rx_fifo_ocy,
  input  logic [7:0]    rx_fifo_dout
);

  localparam int IW = AW - 2;
  localparam logic [IW-1:0] A_GIE    = IW'(0);
  localparam logic [IW-1:0] A_ISR    = IW'(1);
  localparam logic [IW-1:0] A_IER    = IW'(2);
  localparam logic [IW-1:0] A_SOFTR  = IW'(3);
  localparam logic [IW-1:0] A_CR     = IW'(4);
  localparam logic [IW-1:0] A_SR     = IW'(5);
  localparam logic [IW-1:0] A_TXFIFO = IW'(6);
  localparam logic [IW-1:0] A_RXFIFO = IW'(7);
  localparam logic [IW-1:0] A_ADR    = IW'(8);
  localparam logic [IW-1:0] A_TXOCY  = IW'(9);
  localparam logic [IW-1:0] A_RXOCY  = IW'(10);
  localparam logic [IW-1:0] A_RXPIRQ = IW'(11);
  localparam logic [IW-1:0] A_DEB    = IW'(12);
  localparam logic [IW-1:0] A_TSUSTA = IW'(13);
  localparam logic [IW-1:0] A_TBUF   = IW'(20);

  logic [IW-1:0] idx;
  logic [1:0]    unused_paddr;
  logic          access, xfer, wr_en, mapped, is_tim, err, soft_go, soft_pulse;
  logic [2:0]    tm_sel;
  logic [31:0]   rd_val;
  logic [31:0]   tim [8];
  logic          gie;
  logic [7:0]    isr, ier, irq_req_d, isr_set, isr_clr;
  logic [9:0]    tx_din_q;

  assign idx          = paddr[AW-1:2];
  assign unused_paddr = paddr[1:0];
  assign access       = psel & penable;
  assign xfer         = access & pready;
  assign wr_en        = xfer & pwrite;
  assign mapped       = (idx <= A_TBUF);
  assign is_tim       = (idx >= A_TSUSTA) && (idx <= A_TBUF);
  assign tm_sel       = 3'(idx - A_TSUSTA);
  assign soft_go      = wr_en & (idx == A_SOFTR) & (pwdata[3:0] == 4'hA);

  assign err = ~mapped
             | (pwrite  & (idx == A_TXFIFO) & sr[4])
             | (~pwrite & (idx == A_RXFIFO) & sr[6])
             | (pwrite  & (idx == A_SOFTR)  & (pwdata[3:0] != 4'hA));
  assign pslverr = xfer & err;

  // FIFO strobes are qualified by rstn so a reset during the access cycle aborts them
  assign tx_fifo_wr  = rstn & wr_en & (idx == A_TXFIFO) & ~sr[4];
  assign rx_fifo_rd  = rstn & xfer & ~pwrite & (idx == A_RXFIFO) & ~sr[6];
  assign tx_fifo_din = tx_fifo_wr ? pwdata[9:0] : tx_din_q;

  assign isr_set = irq_req & ~irq_req_d;
  assign isr_clr = (wr_en && idx == A_ISR) ? pwdata[7:0] : 8'h00;

  always_comb begin
    rd_val = '0;
    case (idx)
      A_GIE:    rd_val[31]   = gie;
      A_ISR:    rd_val[7:0]  = isr;
      A_IER:    rd_val[7:0]  = ier;
      A_CR:     rd_val[7:0]  = cr;
      A_SR:     rd_val[7:0]  = sr;
      A_RXFIFO: rd_val[7:0]  = sr[6] ? 8'h00 : rx_fifo_dout;
      A_ADR:    rd_val[9:0]  = slv_adr;
      A_TXOCY:  rd_val[4:0]  = tx_fifo_ocy;
      A_RXOCY:  rd_val[4:0]  = rx_fifo_ocy;
      A_RXPIRQ: rd_val[4:0]  = rx_fifo_pirq;
      A_DEB:    rd_val[13:0] = debounce_cnt;
      default:  if (is_tim) rd_val = tim[tm_sel];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      gie          <= 1'b0;
      isr          <= '0;
      ier          <= '0;
      cr           <= '0;
      slv_adr      <= '0;
      rx_fifo_pirq <= '0;
      debounce_cnt <= DB_RST;
      for (int i = 0; i < 8; i++) tim[i] <= T_RST;
      irq_req_d    <= '0;
      irq          <= 1'b0;
      soft_pulse   <= 1'b0;
      tx_din_q     <= '0;
    end else begin
      irq_req_d  <= irq_req;
      irq        <= gie & (|(isr & ier));
      soft_pulse <= soft_go;
      if (tx_fifo_wr) tx_din_q <= pwdata[9:0];
      if (soft_go) begin
        gie          <= 1'b0;
        isr          <= '0;
        ier          <= '0;
        cr           <= 8'h02;
        slv_adr      <= '0;
        rx_fifo_pirq <= '0;
        debounce_cnt <= DB_RST;
        for (int i = 0; i < 8; i++) tim[i] <= T_RST;
      end else begin
        // a set edge in the same cycle as a W1C clear wins
        isr <= (isr & ~isr_clr) | isr_set;
        if (soft_pulse) cr <= 8'h00;
        if (wr_en) begin
          case (idx)
            A_GIE:    gie          <= pwdata[31];
            A_IER:    ier          <= pwdata[7:0];
            A_CR:     cr           <= pwdata[7:0];
            A_ADR:    slv_adr      <= pwdata[9:0];
            A_RXPIRQ: rx_fifo_pirq <= pwdata[4:0];
            A_DEB:    debounce_cnt <= pwdata[13:0];
            default:  if (is_tim) tim[tm_sel] <= pwdata;
          endcase
        end
      end
    end
  end

  assign cr_msms = cr[2];
  assign tsusta  = tim[0];
  assign thdsta  = tim[1];
  assign tsusto  = tim[2];
  assign tsudat  = tim[3];
  assign thddat  = tim[4];
  assign tlow    = tim[5];
  assign thigh   = tim[6];
  assign tbuf    = tim[7];

`ifdef I2C_APB_RDWAIT_EN
  logic        rd_wait;
  logic [31:0] rd_hold;

  // first read cycle samples the data, second cycle completes it
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_wait <= 1'b0;
      rd_hold <= '0;
    end else begin
      rd_wait <= access & ~pwrite & ~rd_wait;
      if (access & ~pwrite & ~rd_wait) rd_hold <= rd_val;
    end
  end

  assign pready = access & (pwrite | rd_wait);
  assign prdata = (xfer & ~pwrite) ? rd_hold : 32'h0;
`else
  assign pready = access;
  assign prdata = (xfer & ~pwrite) ? rd_val : 32'h0;
`endif

endmodule

// File: tb/tb_i2c_apb_regs.sv
// Directed self-checking bench for i2c_apb_regs; handles both the default and I2C_APB_RDWAIT_EN builds.
module tb_i2c_apb_regs;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr, irq, cr_msms, tx_fifo_wr, rx_fifo_rd;
  logic [7:0]  cr;
  logic [9:0]  slv_adr, tx_fifo_din;
  logic [4:0]  rx_fifo_pirq;
  logic [13:0] debounce_cnt;
  logic [31:0] tsusta, thdsta, tsusto, tsudat, thddat, tlow, thigh, tbuf;
  logic [7:0]  sr = '0, irq_req = '0, rx_fifo_dout = '0;
  logic [4:0]  tx_fifo_ocy = '0, rx_fifo_ocy = '0;

  int vec_count = 0, fail_count = 0;
  int tx_seen = 0, rx_seen = 0;
  int tx0, rx0, wait_cnt, exp_rd_wait;
  logic [31:0] rd_data;
  logic        rd_err;

  i2c_apb_regs dut (
    .clk(clk), .rstn(rstn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .irq(irq), .cr(cr), .cr_msms(cr_msms), .slv_adr(slv_adr),
    .tx_fifo_wr(tx_fifo_wr), .tx_fifo_din(tx_fifo_din), .rx_fifo_rd(rx_fifo_rd),
    .rx_fifo_pirq(rx_fifo_pirq), .debounce_cnt(debounce_cnt),
    .tsusta(tsusta), .thdsta(thdsta), .tsusto(tsusto), .tsudat(tsudat),
    .thddat(thddat), .tlow(tlow), .thigh(thigh), .tbuf(tbuf),
    .sr(sr), .irq_req(irq_req), .tx_fifo_ocy(tx_fifo_ocy), .rx_fifo_ocy(rx_fifo_ocy),
    .rx_fifo_dout(rx_fifo_dout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_fifo_wr) tx_seen++;
    if (rx_fifo_rd) rx_seen++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One APB transfer; req_at_access (if nonzero) is driven onto irq_req as the access phase starts
  task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                               input logic [7:0] req_at_access);
    logic done;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge clk); #1;
    penable = 1'b1;
    if (req_at_access != 8'h00) irq_req = req_at_access;
    wait_cnt = 0;
    done = 1'b0;
    rd_data = '0;
    rd_err = 1'b0;
    for (int i = 0; i < 4 && !done; i++) begin
      @(negedge clk);
      if (pready) begin
        done = 1'b1;
        rd_data = prdata;
        rd_err = pslverr;
      end else begin
        wait_cnt++;
        @(posedge clk); #1;
      end
    end
    checkOutput("pready_seen", {31'b0, done}, 32'd1);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
`ifdef I2C_APB_RDWAIT_EN
    exp_rd_wait = 1;
`else
    exp_rd_wait = 0;
`endif
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    checkOutput("rst_irq", {31'b0, irq}, 32'd0);
    checkOutput("rst_cr", {24'b0, cr}, 32'h0);
    checkOutput("rst_tlow", tlow, 32'd100);
    checkOutput("rst_deb", {18'b0, debounce_cnt}, 32'd10);
    checkOutput("rst_txdin", {22'b0, tx_fifo_din}, 32'h0);

    applyStimulus(1'b0, 8'h34, 32'h0, 8'h00);
    checkOutput("rd_tsusta", rd_data, 32'd100);
    checkOutput("rd_tsusta_err", {31'b0, rd_err}, 32'd0);
    applyStimulus(1'b0, 8'h30, 32'h0, 8'h00);
    checkOutput("rd_deb", rd_data, 32'd10);
    applyStimulus(1'b0, 8'h10, 32'h0, 8'h00);
    checkOutput("rd_cr", rd_data, 32'h0);

    // TX FIFO push, then blocked push while full
    tx0 = tx_seen;
    applyStimulus(1'b1, 8'h18, 32'h3A5, 8'h00);
    @(negedge clk);
    checkOutput("tx_strobes", 32'(tx_seen - tx0), 32'd1);
    checkOutput("tx_din", {22'b0, tx_fifo_din}, 32'h3A5);
    checkOutput("tx_err", {31'b0, rd_err}, 32'd0);
    sr = 8'h10;
    tx0 = tx_seen;
    applyStimulus(1'b1, 8'h18, 32'h111, 8'h00);
    @(negedge clk);
    checkOutput("txfull_strobes", 32'(tx_seen - tx0), 32'd0);
    checkOutput("txfull_err", {31'b0, rd_err}, 32'd1);
    checkOutput("txfull_din", {22'b0, tx_fifo_din}, 32'h3A5);

    // RX FIFO pop, then empty
    sr = 8'h00;
    rx_fifo_dout = 8'h5C;
    rx0 = rx_seen;
    applyStimulus(1'b0, 8'h1C, 32'h0, 8'h00);
    @(negedge clk);
    checkOutput("rx_data", rd_data, 32'h5C);
    checkOutput("rx_strobes", 32'(rx_seen - rx0), 32'd1);
    checkOutput("rx_err", {31'b0, rd_err}, 32'd0);
    sr = 8'h40;
    rx0 = rx_seen;
    applyStimulus(1'b0, 8'h1C, 32'h0, 8'h00);
    @(negedge clk);
    checkOutput("rxempty_data", rd_data, 32'h0);
    checkOutput("rxempty_strobes", 32'(rx_seen - rx0), 32'd0);
    checkOutput("rxempty_err", {31'b0, rd_err}, 32'd1);
    checkOutput("sr_read_pending", 32'(sr), 32'h40);
    sr = 8'h00;

    // Unmapped offset
    applyStimulus(1'b0, 8'h54, 32'h0, 8'h00);
    checkOutput("unmap_rd_data", rd_data, 32'h0);
    checkOutput("unmap_rd_err", {31'b0, rd_err}, 32'd1);
    applyStimulus(1'b1, 8'h54, 32'hFFFF_FFFF, 8'h00);
    checkOutput("unmap_wr_err", {31'b0, rd_err}, 32'd1);

    // Interrupt path
    applyStimulus(1'b1, 8'h00, 32'h8000_0000, 8'h00);
    applyStimulus(1'b1, 8'h08, 32'h04, 8'h00);
    @(posedge clk); #1 irq_req = 8'h04;
    @(negedge clk);
    checkOutput("irq_before_isr", {31'b0, irq}, 32'd0);
    @(negedge clk);
    checkOutput("irq_latency", {31'b0, irq}, 32'd0);
    @(negedge clk);
    checkOutput("irq_set", {31'b0, irq}, 32'd1);
    applyStimulus(1'b0, 8'h04, 32'h0, 8'h00);
    checkOutput("isr_set", rd_data, 32'h04);
    applyStimulus(1'b1, 8'h04, 32'h04, 8'h00);
    repeat (2) @(negedge clk);
    checkOutput("irq_cleared", {31'b0, irq}, 32'd0);
    applyStimulus(1'b0, 8'h04, 32'h0, 8'h00);
    checkOutput("isr_cleared", rd_data, 32'h0);
    irq_req = 8'h00;
    repeat (2) @(posedge clk);
    applyStimulus(1'b1, 8'h04, 32'h04, 8'h04);
    applyStimulus(1'b0, 8'h04, 32'h0, 8'h00);
    checkOutput("isr_set_wins", rd_data, 32'h04);
    checkOutput("irq_after_set_wins", {31'b0, irq}, 32'd1);

    // Soft reset
    applyStimulus(1'b1, 8'h10, 32'h0D, 8'h00);
    applyStimulus(1'b1, 8'h48, 32'd500, 8'h00);
    checkOutput("cr_written", {24'b0, cr}, 32'h0D);
    checkOutput("msms", {31'b0, cr_msms}, 32'd1);
    checkOutput("tlow_written", tlow, 32'd500);
    applyStimulus(1'b1, 8'h0C, 32'h0A, 8'h00);
    @(negedge clk);
    checkOutput("softr_cr_pulse", {24'b0, cr}, 32'h02);
    checkOutput("softr_tlow", tlow, 32'd100);
    @(negedge clk);
    checkOutput("softr_cr_after", {24'b0, cr}, 32'h00);
    checkOutput("softr_irq", {31'b0, irq}, 32'd0);
    applyStimulus(1'b0, 8'h04, 32'h0, 8'h00);
    checkOutput("softr_isr", rd_data, 32'h0);
    applyStimulus(1'b1, 8'h10, 32'h0D, 8'h00);
    applyStimulus(1'b1, 8'h48, 32'd500, 8'h00);
    applyStimulus(1'b1, 8'h0C, 32'h05, 8'h00);
    checkOutput("softr_bad_err", {31'b0, rd_err}, 32'd1);
    @(negedge clk);
    checkOutput("softr_bad_cr", {24'b0, cr}, 32'h0D);
    @(negedge clk);
    checkOutput("softr_bad_cr2", {24'b0, cr}, 32'h0D);
    checkOutput("softr_bad_tlow", tlow, 32'd500);

    // Address register and read wait state
    applyStimulus(1'b1, 8'h20, 32'h1F3, 8'h00);
    checkOutput("adr_wr_wait", 32'(wait_cnt), 32'd0);
    checkOutput("slv_adr", {22'b0, slv_adr}, 32'h1F3);
    applyStimulus(1'b0, 8'h20, 32'h0, 8'h00);
    checkOutput("adr_rd", rd_data, 32'h1F3);
    checkOutput("adr_rd_wait", 32'(wait_cnt), 32'(exp_rd_wait));
    applyStimulus(1'b1, 8'h10, 32'h01, 8'h00);
    checkOutput("cr_wr_wait", 32'(wait_cnt), 32'd0);

    // Reset during an access cycle aborts the TX push
    tx0 = tx_seen;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h18; pwdata = 32'h2AA;
    @(posedge clk); #1;
    penable = 1'b1; rstn = 1'b0;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; rstn = 1'b1;
    @(negedge clk);
    checkOutput("abort_strobes", 32'(tx_seen - tx0), 32'd0);
    checkOutput("abort_txdin", {22'b0, tx_fifo_din}, 32'h0);
    checkOutput("abort_cr", {24'b0, cr}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
    $finish;
  end

endmodule
